// File: rtl/pipe_mem_arbiter.sv
// Shares one backing-memory port between instruction fetch and the data stage.
// One transaction in flight; data side wins ties unless it has starved fetch for MAX_DSTREAK grants.
module pipe_mem_arbiter #(
    parameter int WIDTH       = 32,
    parameter int MAX_DSTREAK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic [WIDTH-1:0] i_addr,
    output logic [WIDTH-1:0] i_rdata,
    output logic             i_valid,
    input  logic             d_req,
    input  logic             d_we,
    input  logic [3:0]       d_wstrb,
    input  logic [WIDTH-1:0] d_addr,
    input  logic [WIDTH-1:0] d_wdata,
    output logic [WIDTH-1:0] d_rdata,
    output logic             d_valid,
    output logic             m_req,
    output logic             m_we,
    output logic [3:0]       m_wstrb,
    output logic [WIDTH-1:0] m_addr,
    output logic [WIDTH-1:0] m_wdata,
    input  logic             m_ready,
    input  logic             m_rvalid,
    input  logic [WIDTH-1:0] m_rdata,
    output logic             stall_F,
    output logic             stall_M
);

    localparam logic [2:0] STREAK_LIMIT = 3'(MAX_DSTREAK);
    localparam logic [2:0] STREAK_SAT   = 3'd7;
    localparam int         SIDE_I       = 0;
    localparam int         SIDE_D       = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t           state_reg;
    state_t           state_next;

    logic             owner_reg;
    logic             we_reg;
    logic [3:0]       wstrb_reg;
    logic [WIDTH-1:0] addr_reg;
    logic [WIDTH-1:0] wdata_reg;
    logic [2:0]       dstreak_reg;
    logic [2:0]       dstreak_next;

    logic             grant;
    logic             grant_d;
    logic             capture;

    assign grant   = (state_reg == IDLE) && (i_req || d_req);
    assign grant_d = d_req && !(i_req && (dstreak_reg == STREAK_LIMIT));
    // Completion is only honoured while waiting; stray m_rvalid elsewhere is dropped.
    assign capture = (state_reg == WAIT) && m_rvalid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (grant) begin
                    state_next = REQ;
                end
            end
            REQ: begin
                if (m_ready) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (m_rvalid) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        m_req   = 1'b0;
        i_valid = 1'b0;
        d_valid = 1'b0;
        case (state_reg)
            REQ: begin
                m_req = 1'b1;
            end
            RESP: begin
                i_valid = ~owner_reg;
                d_valid = owner_reg;
            end
            default: begin
                m_req = 1'b0;
            end
        endcase
    end

    // Request fields are frozen at grant so m_* stays stable however long m_ready is withheld.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg <= 1'b0;
            we_reg    <= 1'b0;
            wstrb_reg <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (grant) begin
            owner_reg <= grant_d;
            we_reg    <= grant_d & d_we;
            wstrb_reg <= grant_d ? d_wstrb : 4'b0000;
            addr_reg  <= grant_d ? d_addr : i_addr;
            wdata_reg <= grant_d ? d_wdata : '0;
        end
    end

    always_comb begin
        dstreak_next = dstreak_reg;
        if (grant) begin
            if (grant_d && i_req) begin
                dstreak_next = (dstreak_reg == STREAK_SAT) ? STREAK_SAT : dstreak_reg + 3'd1;
            end else begin
                dstreak_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dstreak_reg <= '0;
        end else begin
            dstreak_reg <= dstreak_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            logic             side_hit;
            logic [WIDTH-1:0] rdata_reg;

            // A store acknowledge carries no data, so the load register keeps its value.
            assign side_hit = capture
                && (owner_reg == 1'(gi == SIDE_D))
                && ((gi == SIDE_I) || !we_reg);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdata_reg <= '0;
                end else if (side_hit) begin
                    rdata_reg <= m_rdata;
                end
            end
        end
    endgenerate

    assign i_rdata = g_side[SIDE_I].rdata_reg;
    assign d_rdata = g_side[SIDE_D].rdata_reg;

    assign m_we    = we_reg;
    assign m_wstrb = wstrb_reg;
    assign m_addr  = addr_reg;
    assign m_wdata = wdata_reg;

    assign stall_M = d_req & ~d_valid;
    assign stall_F = stall_M | (i_req & ~i_valid);

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Scoreboard bench for pipe_mem_arbiter: requester tasks push expected read data, a negedge
// monitor pops on each valid pulse and checks arbitration order, m_* stability and stall outputs.
module tb_pipe_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_req = 1'b0;
    logic [31:0] i_addr = '0;
    logic [31:0] i_rdata;
    logic        i_valid;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [3:0]  d_wstrb = '0;
    logic [31:0] d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic        m_req;
    logic        m_we;
    logic [3:0]  m_wstrb;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ready = 1'b0;
    logic        m_rvalid = 1'b0;
    logic [31:0] m_rdata = '0;
    logic        stall_F;
    logic        stall_M;

    always #5 clk = ~clk;

    pipe_mem_arbiter #(.WIDTH(32), .MAX_DSTREAK(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_valid(i_valid),
        .d_req(d_req), .d_we(d_we), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .m_req(m_req), .m_we(m_we), .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .stall_F(stall_F), .stall_M(stall_M)
    );

    int compared = 0;
    int mismatched = 0;

    logic [31:0] iq[$];
    logic [31:0] dq[$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] exp_d_last = '0;

    bit mem_auto = 1'b1;
    int rdy_min = 0, rdy_max = 0, rv_min = 0, rv_max = 0;

    logic [63:0] grant_hist = '0;

    function automatic logic [31:0] defval(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : defval(a);
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : defval(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Backing memory: random accept and completion delays, stray m_rvalid outside real completions.
    int          resp_phase = 0, resp_cnt = 0, resp_rdy_d = 0, resp_rv_d = 0;
    logic [31:0] resp_data = '0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!mem_auto || !rst) begin
                resp_phase = 0;
                resp_cnt = 0;
                continue;
            end
            m_ready = 1'b0;
            m_rvalid = 1'b0;
            m_rdata = $urandom;
            if (resp_phase == 0) begin
                if (m_req) begin
                    if (resp_cnt == 0) resp_rdy_d = $urandom_range(rdy_max, rdy_min);
                    if (resp_cnt >= resp_rdy_d) begin
                        m_ready = 1'b1;
                        if (m_we) mem[m_addr] = merge(mem_read(m_addr), m_wdata, m_wstrb);
                        resp_data = mem_read(m_addr);
                        resp_rv_d = $urandom_range(rv_max, rv_min);
                        resp_phase = 1;
                        resp_cnt = 0;
                    end else begin
                        resp_cnt++;
                    end
                end
                if ($urandom_range(3, 0) == 0) m_rvalid = 1'b1;
            end else begin
                if (resp_cnt >= resp_rv_d) begin
                    m_rvalid = 1'b1;
                    m_rdata = resp_data;
                    resp_phase = 0;
                    resp_cnt = 0;
                end else begin
                    resp_cnt++;
                end
            end
        end
    end

    // Monitor: reference arbitration (streak counter), scoreboard pops, stability and stall rules.
    logic        mon_prev_mreq = 0, mon_prev_i = 0, mon_prev_d = 0, mon_pending = 0;
    int          mon_streak = 0;
    logic [31:0] mon_addr = '0, mon_wdata = '0;
    logic [3:0]  mon_wstrb = '0;
    logic        mon_we = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                mon_prev_mreq = 0; mon_prev_i = 0; mon_prev_d = 0; mon_pending = 0;
                mon_streak = 0;
                continue;
            end
            check("stall_M", stall_M, d_req & ~d_valid);
            check("stall_F", stall_F, (d_req & ~d_valid) | (i_req & ~i_valid));
            if (i_valid) begin
                if (iq.size() == 0) check("i_valid_unexpected", i_valid, 0);
                else check("i_rdata", i_rdata, iq.pop_front());
            end
            if (d_valid) begin
                if (dq.size() == 0) check("d_valid_unexpected", d_valid, 0);
                else check("d_rdata", d_rdata, dq.pop_front());
            end
            if (mon_pending) begin
                check("m_req_held", m_req, 1);
                check("m_addr_stable", m_addr, mon_addr);
                check("m_we_stable", m_we, mon_we);
                check("m_wstrb_stable", m_wstrb, mon_wstrb);
                check("m_wdata_stable", m_wdata, mon_wdata);
            end
            if (m_req && !mon_prev_mreq) begin
                logic owner_d;
                owner_d = mon_prev_d && !(mon_prev_i && mon_streak == 4);
                if (owner_d && mon_prev_i) mon_streak = (mon_streak == 7) ? 7 : mon_streak + 1;
                else mon_streak = 0;
                grant_hist = {grant_hist[62:0], owner_d};
                if (owner_d) begin
                    check("grant_addr_d", m_addr, d_addr);
                    check("grant_we_d", m_we, d_we);
                    if (d_we) begin
                        check("grant_wstrb_d", m_wstrb, d_wstrb);
                        check("grant_wdata_d", m_wdata, d_wdata);
                    end
                end else begin
                    check("grant_addr_i", m_addr, i_addr);
                    check("grant_we_i", m_we, 0);
                    check("grant_wstrb_i", m_wstrb, 0);
                end
            end
            mon_prev_mreq = m_req;
            mon_prev_i = i_req;
            mon_prev_d = d_req;
            mon_pending = m_req && !m_ready;
            mon_addr = m_addr; mon_we = m_we; mon_wstrb = m_wstrb; mon_wdata = m_wdata;
        end
    end

    task automatic i_txn(input logic [31:0] addr);
        int n;
        @(posedge clk);
        #1;
        iq.push_back(ref_read(addr));
        i_addr = addr;
        i_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!i_valid && n < 200);
        if (!i_valid) check("i_timeout", i_valid, 1);
        i_req = 1'b0;
    endtask

    task automatic d_txn(input logic we, input logic [3:0] strb, input logic [31:0] addr,
                         input logic [31:0] wd);
        int n;
        @(posedge clk);
        #1;
        if (we) begin
            dq.push_back(exp_d_last);
            ref_mem[addr] = merge(ref_read(addr), wd, strb);
        end else begin
            exp_d_last = ref_read(addr);
            dq.push_back(exp_d_last);
        end
        d_we = we; d_wstrb = strb; d_addr = addr; d_wdata = wd;
        d_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!d_valid && n < 200);
        if (!d_valid) check("d_timeout", d_valid, 1);
        d_req = 1'b0;
    endtask

    function automatic logic [31:0] rand_iaddr();
        return 32'h1000 + 32'($urandom_range(63, 0)) * 4;
    endfunction

    function automatic logic [31:0] rand_daddr();
        return 32'h2000 + 32'($urandom_range(15, 0)) * 4;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, compared %0d", compared);
        $fatal(1, "watchdog");
    end

    initial begin
        int dcyc, icyc, cyc, n;
        mem[32'h10] = 32'h00500093;
        ref_mem[32'h10] = 32'h00500093;

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_req", m_req, 0);
        check("rst_i_valid", i_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_m_addr", m_addr, 0);
        check("rst_i_rdata", i_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        rst = 1'b1;

        // Single fetch, zero-wait memory: valid on cycle 4, stall_F on cycles 1-3.
        @(posedge clk);
        #1;
        iq.push_back(32'h00500093);
        i_addr = 32'h10;
        i_req = 1'b1;
        #1;
        check("lat_stall_F_c1", stall_F, 1);
        for (int c = 2; c <= 4; c++) begin
            @(posedge clk);
            #1;
            if (c == 2) begin
                check("lat_m_req", m_req, 1);
                check("lat_m_addr", m_addr, 32'h10);
                check("lat_m_we", m_we, 0);
            end
            if (c < 4) begin
                check("lat_stall_F", stall_F, 1);
                check("lat_i_valid_early", i_valid, 0);
            end else begin
                check("lat_i_valid_c4", i_valid, 1);
            end
        end
        i_req = 1'b0;

        // Simultaneous requests: data side first (cycle 4), fetch four cycles later.
        @(posedge clk);
        #1;
        exp_d_last = ref_read(32'h100);
        dq.push_back(exp_d_last);
        iq.push_back(ref_read(32'h1004));
        d_we = 0; d_addr = 32'h100; d_req = 1'b1;
        i_addr = 32'h1004; i_req = 1'b1;
        dcyc = 0; icyc = 0; cyc = 1;
        #1;
        while (cyc < 30 && (dcyc == 0 || icyc == 0)) begin
            if (dcyc == 0 && !d_valid) check("both_stall_M", stall_M, 1);
            if (d_valid && dcyc == 0) begin dcyc = cyc; d_req = 1'b0; end
            if (i_valid && icyc == 0) begin icyc = cyc; i_req = 1'b0; end
            if (dcyc == 0 || icyc == 0) begin
                @(posedge clk);
                #1;
                cyc++;
            end
        end
        check("both_d_cycle", dcyc, 4);
        check("both_i_cycle", icyc, 8);
        d_req = 1'b0; i_req = 1'b0;

        // Partial store, then reload to see the merged word.
        d_txn(1'b1, 4'b0011, 32'h100, 32'hDEADBEEF);
        d_txn(1'b0, 4'b0000, 32'h100, 32'h0);

        // Memory holds off acceptance for 5 cycles.
        rdy_min = 5; rdy_max = 5;
        i_txn(32'h1008);
        d_txn(1'b1, 4'b1100, 32'h2000, 32'hCAFEF00D);
        rdy_min = 0; rdy_max = 0;

        // Flushed load: request drops after grant, completion still pulses.
        @(posedge clk);
        #1;
        exp_d_last = ref_read(32'h2004);
        dq.push_back(exp_d_last);
        d_we = 0; d_addr = 32'h2004; d_req = 1'b1;
        @(posedge clk);
        #1;
        d_req = 1'b0;
        n = 0;
        while (!d_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("flush_d_valid", d_valid, 1);

        // Both sides re-request every IDLE: expect dddd i repeating.
        rdy_min = 0; rdy_max = 2; rv_min = 0; rv_max = 2;
        grant_hist = '0;
        fork
            begin
                repeat (3) i_txn(rand_iaddr());
            end
            begin
                repeat (12) d_txn(1'($urandom_range(1, 0)), 4'($urandom), rand_daddr(), $urandom);
            end
        join
        check("starve_pattern", grant_hist[31:0], 32'b111101111011110);

        // Random traffic with random gaps and memory latencies.
        rdy_min = 0; rdy_max = 3; rv_min = 0; rv_max = 3;
        fork
            begin
                repeat (40) begin
                    repeat ($urandom_range(3, 0)) @(posedge clk);
                    i_txn(rand_iaddr());
                end
            end
            begin
                repeat (60) begin
                    repeat ($urandom_range(3, 0)) @(posedge clk);
                    d_txn(1'($urandom_range(1, 0)), 4'($urandom), rand_daddr(), $urandom);
                end
            end
        join

        // Reset while waiting for completion; late m_rvalid must be ignored.
        mem_auto = 1'b0;
        @(posedge clk);
        #1;
        m_ready = 1'b0; m_rvalid = 1'b0;
        d_we = 0; d_addr = 32'h2008; d_req = 1'b1;
        n = 0;
        while (!m_req && n < 10) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("rstw_m_req", m_req, 1);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check("rstw_in_wait", m_req, 0);
        rst = 1'b0;
        d_req = 1'b0;
        #1;
        exp_d_last = '0;
        check("rstw_m_req0", m_req, 0);
        check("rstw_m_we", m_we, 0);
        check("rstw_m_wstrb", m_wstrb, 0);
        check("rstw_m_addr", m_addr, 0);
        check("rstw_m_wdata", m_wdata, 0);
        check("rstw_d_valid", d_valid, 0);
        check("rstw_i_valid", i_valid, 0);
        check("rstw_i_rdata", i_rdata, 0);
        check("rstw_d_rdata", d_rdata, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        m_rvalid = 1'b1;
        m_rdata = 32'hBADC0DE5;
        @(posedge clk);
        #1;
        m_rvalid = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            check("rstw_no_d_valid", d_valid, 0);
            check("rstw_no_m_req", m_req, 0);
        end
        check("rstw_d_rdata_kept", d_rdata, 0);
        mem_auto = 1'b1;
        rdy_min = 0; rdy_max = 1; rv_min = 0; rv_max = 1;
        d_txn(1'b0, 4'b0000, 32'h2008, 32'h0);
        i_txn(32'h1010);

        repeat (5) @(posedge clk);
        check("iq_drained", iq.size(), 0);
        check("dq_drained", dq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
